// File: rtl/cp0_int_ctrl_pkg.sv
// Shared definitions for the CP0 hardware-interrupt sequencer: state encodings,
// default line count and the widths of the grant index and hold-off counter.
package cp0_int_ctrl_pkg;

    localparam int CP0I_NUM_SRC = 6;
    localparam int CP0I_ID_W    = 3;
    localparam int CP0I_CNT_W   = 4;

    typedef enum logic [1:0] {
        CP0I_IDLE    = 2'd0,
        CP0I_PRESENT = 2'd1,
        CP0I_HOLDOFF = 2'd2
    } cp0i_state_e;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Bundle between the interrupt sequencer (slave) and its environment / CP0 (master).
// int_o is a request held stable while PRESENT; int_ack is a one-cycle take pulse that
// only has an effect while a line is presented, and int_o drops on the cycle after it.
interface cp0_int_ctrl_if #(
    parameter int NUM_SRC = cp0_int_ctrl_pkg::CP0I_NUM_SRC
);
    import cp0_int_ctrl_pkg::*;

    logic [NUM_SRC-1:0]   irq_src;
    logic [NUM_SRC-1:0]   irq_edge_cfg;
    logic [NUM_SRC-1:0]   cp0_status_im;
    logic                 cp0_status_ie;
    logic                 cp0_status_exl;
    logic                 int_ack;

    logic [NUM_SRC-1:0]   int_o;
    logic [CP0I_ID_W-1:0] grant_id;
    logic                 int_busy;
    cp0i_state_e          dbg_state;

    modport master (
        output irq_src, irq_edge_cfg, cp0_status_im, cp0_status_ie, cp0_status_exl, int_ack,
        input  int_o, grant_id, int_busy, dbg_state
    );

    modport slave (
        input  irq_src, irq_edge_cfg, cp0_status_im, cp0_status_ie, cp0_status_exl, int_ack,
        output int_o, grant_id, int_busy, dbg_state
    );

endinterface

// File: rtl/cp0_int_ctrl_sync.sv
// Per-line synchroniser: SYNC_STAGES flop chain for an asynchronous input plus a
// one-cycle history copy of the synchronised value for rising-edge detection.
module cp0_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic s_d
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            s_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt request sequencer feeding CP0 int_i: synchronises and latches requests,
// grants one line at a time (highest index wins) and enforces a hold-off after each take.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = CP0I_NUM_SRC,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4
) (
    input  logic           clk,
    input  logic           rst,
    cp0_int_ctrl_if.slave  bus
);

    localparam logic [CP0I_CNT_W-1:0] HOLD_LOAD = CP0I_CNT_W'(HOLDOFF - 1);

    logic [NUM_SRC-1:0]    s;
    logic [NUM_SRC-1:0]    s_d;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    pending_nxt;
    logic [NUM_SRC-1:0]    ack_clr;
    logic [NUM_SRC-1:0]    elig;
    logic                  int_gate;
    logic                  any_elig;
    logic                  granted_elig;
    logic [CP0I_ID_W-1:0]  winner;
    logic [NUM_SRC-1:0]    winner_oh;

    cp0i_state_e           state;
    logic [CP0I_CNT_W-1:0] hold_cnt;
    logic [NUM_SRC-1:0]    int_o_q;
    logic [CP0I_ID_W-1:0]  grant_id_q;
    logic                  int_busy_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        cp0_int_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (bus.irq_src[i]),
            .s   (s[i]),
            .s_d (s_d[i])
        );
    end

    // An edge arriving on the same cycle as its take keeps the line pending.
    always_comb begin
        ack_clr = '0;
        if (state == CP0I_PRESENT && bus.int_ack) begin
            ack_clr[grant_id_q] = 1'b1;
        end
        pending_nxt = (bus.irq_edge_cfg & ((s & ~s_d) | (pending & ~ack_clr)))
                    | (~bus.irq_edge_cfg & s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        int_gate     = bus.cp0_status_ie & ~bus.cp0_status_exl;
        elig         = pending & bus.cp0_status_im & {NUM_SRC{int_gate}};
        granted_elig = elig[grant_id_q];
    end

    // Ascending scan so the highest eligible index is the last one written.
    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i]) begin
                winner   = CP0I_ID_W'(i);
                any_elig = 1'b1;
            end
        end
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CP0I_IDLE;
            hold_cnt   <= '0;
            int_o_q    <= '0;
            grant_id_q <= '0;
            int_busy_q <= 1'b0;
        end else begin
            case (state)
                CP0I_IDLE: begin
                    if (any_elig) begin
                        state      <= CP0I_PRESENT;
                        grant_id_q <= winner;
                        int_o_q    <= winner_oh;
                        int_busy_q <= 1'b1;
                    end
                end
                CP0I_PRESENT: begin
                    if (bus.int_ack) begin
                        state      <= CP0I_HOLDOFF;
                        hold_cnt   <= HOLD_LOAD;
                        int_o_q    <= '0;
                        int_busy_q <= 1'b1;
                    end else if (!granted_elig) begin
                        state      <= CP0I_IDLE;
                        int_o_q    <= '0;
                        int_busy_q <= 1'b0;
                    end
                end
                CP0I_HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state      <= CP0I_IDLE;
                        int_busy_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= CP0I_IDLE;
                    hold_cnt   <= '0;
                    int_o_q    <= '0;
                    int_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_o     = int_o_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.int_busy  = int_busy_q;
    assign bus.dbg_state = state;

endmodule
